conv_pool_sequencer: RTL and testbench

Controls one convolution engine and one max-pooling engine, one channel at a time. For each channel it releases the convolution engine from reset and waits for its done. It then releases the pooling engine and waits for its done. Last, it hands the pooled result to a store stage through a valid/ready handshake. The block sits above the conv and maxpooling datapath. It is the only driver of their active-low resets, so it controls when each engine starts and restarts.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/conv_pool_sequencer_phase_watchdog.sv | 40 ++++
 rtl/conv_pool_sequencer.sv | 115 +++++++++++
 tb/tb_conv_pool_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the conv/pool sequencer.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV_RUN = 3'd1,
    POOL_RUN = 3'd2,
    STORE    = 3'd3,
    GAP      = 3'd4,
    DONE     = 3'd5,
    ERROR    = 3'd6
  } seq_state_e;

  localparam int unsigned WDT_CYCLES_DEFAULT = 4096;

endpackage

// File: rtl/conv_pool_sequencer_phase_watchdog.sv
// Phase watchdog: counts cycles spent in an engine phase and flags when the
// count reaches LIMIT. The count saturates at LIMIT so the flag stays high.
module phase_watchdog
  import cnn_pkg::*;
#(
  parameter int unsigned LIMIT = WDT_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == W'(LIMIT));

  // Next count: clear wins over counting; hold once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_pool_sequencer.sv
// Conv/pool channel sequencer: runs conv, then pool, then hands the pooled
// result to the store stage, once per channel. Sole driver of both engine
// active-low resets. Optional watchdog enabled by defining SEQ_WATCHDOG_EN.
module conv_pool_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned WDT_CYCLES = WDT_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] ch_idx,
  output logic             conv_nreset,
  input  logic             conv_done,
  output logic             pool_nreset,
  input  logic             pool_done,
  output logic             store_valid,
  input  logic             store_ready,
  output logic             frame_done,
  output logic             error
);

  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] ch_q, ch_d;
  logic             wdt_expired;

`ifdef SEQ_WATCHDOG_EN
  logic wdt_clr;
  logic wdt_en;

  // Timed phases are the two engine runs; STORE stalls are never timed.
  assign wdt_en  = (state_q == CONV_RUN) || (state_q == POOL_RUN);
  assign wdt_clr = (state_d != state_q) &&
                   ((state_d == CONV_RUN) || (state_d == POOL_RUN));

  phase_watchdog #(
    .LIMIT(WDT_CYCLES)
  ) u_wdt (
    .clock    (clock),
    .reset    (reset),
    .clr_i    (wdt_clr),
    .en_i     (wdt_en),
    .expired_o(wdt_expired)
  );

  assign error = (state_q == ERROR);
`else
  assign wdt_expired = 1'b0;
  // No watchdog built: error is constant low.
  assign error = (WDT_CYCLES == 0) & 1'b0;
`endif

  // Outputs decoded from the state register only.
  assign busy        = (state_q != IDLE);
  assign conv_nreset = (state_q == CONV_RUN) || (state_q == POOL_RUN) ||
                       (state_q == STORE);
  assign pool_nreset = (state_q == POOL_RUN) || (state_q == STORE);
  assign store_valid = (state_q == STORE);
  assign frame_done  = (state_q == DONE);
  assign ch_idx      = ch_q;

  // Next-state and channel counter update; done beats watchdog expiry.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      IDLE: begin
        ch_d = '0;
        if (start) state_d = CONV_RUN;
      end
      CONV_RUN: begin
        if (conv_done)        state_d = POOL_RUN;
        else if (wdt_expired) state_d = ERROR;
      end
      POOL_RUN: begin
        if (pool_done)        state_d = STORE;
        else if (wdt_expired) state_d = ERROR;
      end
      STORE: begin
        if (store_ready) begin
          if (ch_q == LAST_CH) begin
            state_d = DONE;
          end else begin
            state_d = GAP;
            ch_d    = ch_q + CNT_W'(1);
          end
        end
      end
      GAP: state_d = CONV_RUN;
      DONE: begin
        state_d = IDLE;
        ch_d    = '0;
      end
      ERROR: state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  // State and channel registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

endmodule

// File: tb/tb_conv_pool_sequencer.sv
// Bench for conv_pool_sequencer: scripted per-phase timeline supplies the
// expected outputs of every cycle; one compare process checks them.
module tb_conv_pool_sequencer;

  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int WDT = 32;

  logic          clock = 1'b0;
  logic          reset, start, conv_done, pool_done, store_ready;
  logic          busy, conv_nreset, pool_nreset, store_valid, frame_done, error;
  logic [CW-1:0] ch_idx;

  conv_pool_sequencer #(
    .NUM_CH    (NCH),
    .CNT_W     (CW),
    .WDT_CYCLES(WDT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .ch_idx     (ch_idx),
    .conv_nreset(conv_nreset),
    .conv_done  (conv_done),
    .pool_nreset(pool_nreset),
    .pool_done  (pool_done),
    .store_valid(store_valid),
    .store_ready(store_ready),
    .frame_done (frame_done),
    .error      (error)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic          e_en = 1'b0;
  logic          e_busy, e_cn, e_pn, e_sv, e_fd, e_err;
  logic [CW-1:0] e_ch;
  int            hold = 0;

  int cyc_n = 0, start_cyc = 0, first_sv = -1;
  int xfers = 0, fds = 0, gaps = 0;
  bit sv_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process plus event counters used by the literal checks.
  always @(negedge clock) begin
    cyc_n++;
    if (e_en) begin
      chk("busy",        32'(busy),        32'(e_busy));
      chk("ch_idx",      32'(ch_idx),      32'(e_ch));
      chk("conv_nreset", 32'(conv_nreset), 32'(e_cn));
      chk("pool_nreset", 32'(pool_nreset), 32'(e_pn));
      chk("store_valid", 32'(store_valid), 32'(e_sv));
      chk("frame_done",  32'(frame_done),  32'(e_fd));
      chk("error",       32'(error),       32'(e_err));
    end
    if (!busy && start && !reset) begin
      start_cyc = cyc_n;
      sv_seen   = 1'b0;
    end
    if (store_valid && !sv_seen) begin
      first_sv = cyc_n - start_cyc;
      sv_seen  = 1'b1;
    end
    if (store_valid && store_ready) xfers++;
    if (frame_done) fds++;
    if (busy && !conv_nreset && !pool_nreset && !frame_done && !error) gaps++;
  end

  // One cycle: drive inputs, publish what the outputs must be this cycle.
  task automatic step(input logic st, cd, pd, rdy, rst,
                      input logic eb, ecn, epn, esv, efd, eer, input int ech);
    start       = st | (hold > 0);
    if (hold > 0) hold--;
    conv_done   = cd;
    pool_done   = pd;
    store_ready = rdy;
    reset       = rst;
    e_busy = eb; e_cn = ecn; e_pn = epn; e_sv = esv; e_fd = efd; e_err = eer;
    e_ch   = ech[CW-1:0];
    e_en   = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic st);
    step(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Full frame timeline: conv_done arrives cl cycles after CONV_RUN entry,
  // pool_done pl cycles after POOL_RUN entry, ready after 'stall' refusals.
  task automatic run_frame(input int cl, pl, stall, input bit both_first, noise,
                           input int abort_ch, abort_at);
    idle(1'b1);
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i <= cl; i++)
        step(1'b0, i == cl, both_first && i == 0, 1'b0, 1'b0,
             1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c);
      for (int i = 0; i <= pl; i++) begin
        if (c == abort_ch && i == abort_at) begin
          step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c);
          idle(1'b0);
          return;
        end
        step(1'b0, noise, i == pl, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c);
      end
      for (int i = 0; i <= stall; i++)
        step(1'b0, noise, noise, i == stall, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, c);
      if (c < NCH - 1)
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c + 1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, NCH - 1);
  endtask

  initial begin
    start = 1'b0; conv_done = 1'b0; pool_done = 1'b0; store_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(1'b0);

    // Basic two-channel frame.
    xfers = 0; fds = 0; gaps = 0; first_sv = -1;
    run_frame(10, 20, 0, 1'b0, 1'b0, -1, 0);
    idle(1'b0);
    idle(1'b0);
    chk("t1_transfers", 32'(xfers), 32'd2);
    chk("t1_frame_pulses", 32'(fds), 32'd1);
    chk("t1_gap_cycles", 32'(gaps), 32'd1);
    chk("t1_start_to_store", 32'(first_sv), 32'd33);

    // start held for 50 cycles: a single frame only.
    fds = 0;
    hold = 50;
    run_frame(15, 15, 0, 1'b0, 1'b0, -1, 0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    chk("t2_frame_pulses", 32'(fds), 32'd1);

    // Ready stalls of 7 cycles, stray done pulses outside their phases.
    xfers = 0;
    run_frame(4, 6, 7, 1'b0, 1'b1, -1, 0);
    idle(1'b0);
    chk("t3_transfers", 32'(xfers), 32'd2);

    // conv_done and pool_done together in the first CONV_RUN cycle.
    first_sv = -1;
    run_frame(0, 5, 0, 1'b1, 1'b0, -1, 0);
    idle(1'b0);
    chk("t4_start_to_store", 32'(first_sv), 32'd8);

    // Reset in POOL_RUN of channel 1, then a clean restart from channel 0.
    xfers = 0;
    run_frame(5, 8, 0, 1'b0, 1'b0, 1, 3);
    idle(1'b0);
    chk("t5_transfers_before_abort", 32'(xfers), 32'd1);
    run_frame(3, 4, 1, 1'b0, 1'b0, -1, 0);
    idle(1'b0);
    chk("t5_transfers_total", 32'(xfers), 32'd3);

`ifdef SEQ_WATCHDOG_EN
    // conv_done never arrives: ERROR from cycle WDT+1 after CONV_RUN entry.
    idle(1'b1);
    for (int i = 0; i <= WDT; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    idle(1'b0);
    idle(1'b0);
`endif

    e_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
